// File: rtl/quantr_i_fetch_unit.sv
// Instruction-fetch front end: pipelined in-order ROM requests feeding a prefetch FIFO
// of {pc, inst} pairs, with redirect flush and dropping of stale in-flight responses.
module quantr_i_fetch_unit #(
   parameter int unsigned     XLEN            = 64,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int unsigned     FIFO_DEPTH      = 4,
   parameter int unsigned     MAX_OUTSTANDING = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            rom_ce_o,
   output logic [XLEN-1:0] rom_addr_o,
   input  logic            rom_valid_i,
   input  logic [31:0]     rom_data_i,
   output logic            inst_valid_o,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   input  logic            inst_ready_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] pc_out,
   output logic            err_o
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] target_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
   logic [31:0]     inst_mem [FIFO_DEPTH];
   logic            issue;
   logic            resp_ok;
   logic            spurious;
   logic            push;
   logic            pop;

   // outstanding counts every in-flight request, dropped ones included, so the credit
   // check below reserves a FIFO slot for each request still on its way back.
   always_comb begin
      issue    = 1'b0;
      if (rst && !redirect_i && (32'(outstanding) < MAX_OUTSTANDING) &&
          ((32'(fifo_count) + 32'(outstanding)) < FIFO_DEPTH))
         issue = 1'b1;
      resp_ok  = rom_valid_i && (outstanding != '0);
      spurious = rom_valid_i && (outstanding == '0);
      push     = resp_ok && (drop_cnt == '0) && !redirect_i;
      pop      = inst_valid_o && inst_ready_i;
   end

   assign target_pc    = redirect_pc_i & ~XLEN'(3);
   assign rom_ce_o     = issue;
   assign rom_addr_o   = fetch_pc;
   assign pc_out       = fetch_pc;
   assign inst_valid_o = (fifo_count != '0);
   assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : '0;
   assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         err_o       <= 1'b0;
      end else begin
         outstanding <= outstanding + OW'(issue) - OW'(resp_ok);
         if (spurious)
            err_o <= 1'b1;
         if (redirect_i) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            fetch_pc   <= target_pc;
            resp_pc    <= target_pc;
            drop_cnt   <= outstanding - OW'(resp_ok);
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
         end else begin
            if (issue)
               fetch_pc <= fetch_pc + XLEN'(4);
            if (push) begin
               resp_pc <= resp_pc + XLEN'(4);
               wr_ptr  <= wr_ptr + PW'(1);
            end
            if (resp_ok && (drop_cnt != '0))
               drop_cnt <= drop_cnt - OW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= resp_pc;
         inst_mem[wr_ptr] <= rom_data_i;
      end
   end
endmodule

// File: tb/tb_quantr_i_fetch_unit.sv
// Directed bench for quantr_i_fetch_unit: a latency-configurable ROM responder plus
// in-order trackers for issued addresses and delivered instructions.
module tb_quantr_i_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        romCe;
   logic [63:0] romAddr;
   logic        romValid;
   logic [31:0] romData;
   logic        instValid;
   logic [31:0] inst;
   logic [63:0] instPc;
   logic        instReady;
   logic        redirect;
   logic [63:0] redirectPc;
   logic [63:0] pcOut;
   logic        err;

   logic        zeroBit  = 1'b0;
   logic [31:0] zeroInst = '0;
   logic [63:0] zeroWord = '0;
   logic        wrapCe;
   logic [63:0] wrapAddr;
   logic        wrapValid;
   logic [31:0] wrapInst;
   logic [63:0] wrapPc;
   logic [63:0] wrapPcOut;
   logic        wrapErr;

   int          testsRun = 0;
   int          failCount = 0;
   int          cycle = 0;
   int          romLatency = 1;
   int          issuedCount = 0;
   int          deliveredCount = 0;
   logic        spurPulse = 1'b0;
   logic [63:0] expIssue = '0;
   logic [63:0] expPc = '0;
   logic [63:0] pendAddr [$];
   int          pendDue [$];

   always #5 clk = ~clk;

   quantr_i_fetch_unit dut (
      .clk(clk), .rst(rst), .rom_ce_o(romCe), .rom_addr_o(romAddr),
      .rom_valid_i(romValid), .rom_data_i(romData), .inst_valid_o(instValid),
      .inst_o(inst), .inst_pc_o(instPc), .inst_ready_i(instReady),
      .redirect_i(redirect), .redirect_pc_i(redirectPc), .pc_out(pcOut), .err_o(err)
   );

   quantr_i_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dutWrap (
      .clk(clk), .rst(rst), .rom_ce_o(wrapCe), .rom_addr_o(wrapAddr),
      .rom_valid_i(zeroBit), .rom_data_i(zeroInst), .inst_valid_o(wrapValid),
      .inst_o(wrapInst), .inst_pc_o(wrapPc), .inst_ready_i(zeroBit),
      .redirect_i(zeroBit), .redirect_pc_i(zeroWord), .pc_out(wrapPcOut), .err_o(wrapErr)
   );

   function automatic logic [31:0] romWord(input logic [63:0] addr);
      return addr[31:0] ^ 32'h5A3C_0F01;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle: observe requests and deliveries mid-cycle, then play the ROM.
   task automatic applyStimulus();
      @(negedge clk);
      if (romCe) begin
         checkOutput("issueAddr", romAddr, expIssue);
         expIssue = expIssue + 64'd4;
         issuedCount++;
         pendAddr.push_back(romAddr);
         pendDue.push_back(cycle + romLatency);
      end
      if (instValid && instReady) begin
         checkOutput("deliverPc", instPc, expPc);
         checkOutput("deliverInst", 64'(inst), 64'(romWord(expPc)));
         expPc = expPc + 64'd4;
         deliveredCount++;
      end
      @(posedge clk);
      #1;
      cycle++;
      romValid = 1'b0;
      romData  = '0;
      if (spurPulse) begin
         romValid  = 1'b1;
         romData   = 32'hDEAD_BEEF;
         spurPulse = 1'b0;
      end else if (pendDue.size() > 0 && pendDue[0] <= cycle) begin
         romValid = 1'b1;
         romData  = romWord(pendAddr[0]);
         void'(pendAddr.pop_front());
         void'(pendDue.pop_front());
      end
   endtask

   task automatic applyReset(input logic ready, input int latency);
      rst        = 1'b0;
      redirect   = 1'b0;
      redirectPc = '0;
      instReady  = ready;
      romLatency = latency;
      pendAddr.delete();
      pendDue.delete();
      applyStimulus();
      applyStimulus();
      checkOutput("rstCe", 64'(romCe), 64'd0);
      checkOutput("rstAddr", romAddr, 64'd0);
      checkOutput("rstPcOut", pcOut, 64'd0);
      checkOutput("rstValid", 64'(instValid), 64'd0);
      checkOutput("rstInst", 64'(inst), 64'd0);
      checkOutput("rstInstPc", instPc, 64'd0);
      checkOutput("rstErr", 64'(err), 64'd0);
      expIssue       = '0;
      expPc          = '0;
      issuedCount    = 0;
      deliveredCount = 0;
      rst            = 1'b1;
   endtask

   initial begin
      rst        = 1'b0;
      romValid   = 1'b0;
      romData    = '0;
      instReady  = 1'b0;
      redirect   = 1'b0;
      redirectPc = '0;

      // Streaming at latency 1: one instruction per cycle once the pipe has filled.
      applyReset(1'b1, 1);
      for (int i = 0; i < 20; i++)
         applyStimulus();
      checkOutput("streamCount", 64'(deliveredCount), 64'd18);

      // Core stalled: credit limit stops issue after four requests.
      applyReset(1'b0, 1);
      for (int i = 0; i < 10; i++)
         applyStimulus();
      checkOutput("stallIssued", 64'(issuedCount), 64'd4);
      checkOutput("stallCe", 64'(romCe), 64'd0);
      checkOutput("stallValid", 64'(instValid), 64'd1);
      checkOutput("stallHeadPc", instPc, 64'd0);
      checkOutput("stallHeadInst", 64'(inst), 64'(romWord(64'd0)));
      instReady = 1'b1;
      for (int i = 0; i < 4; i++)
         applyStimulus();
      checkOutput("drainCount", 64'(deliveredCount), 64'd4);

      // Redirect with three requests in flight at latency 3.
      applyReset(1'b1, 3);
      for (int i = 0; i < 3; i++)
         applyStimulus();
      checkOutput("preRedirIssued", 64'(issuedCount), 64'd3);
      redirect   = 1'b1;
      redirectPc = 64'h100;
      #1;
      checkOutput("redirCe", 64'(romCe), 64'd0);
      expIssue = 64'h100;
      expPc    = 64'h100;
      applyStimulus();
      redirect = 1'b0;
      checkOutput("redirValid", 64'(instValid), 64'd0);
      for (int i = 0; i < 12; i++)
         applyStimulus();
      checkOutput("redirDelivered", 64'(deliveredCount > 0), 64'd1);
      checkOutput("redirErr", 64'(err), 64'd0);

      // Misaligned redirect target is forced to a word boundary.
      applyReset(1'b1, 1);
      redirect   = 1'b1;
      redirectPc = 64'h103;
      expIssue   = 64'h100;
      expPc      = 64'h100;
      applyStimulus();
      redirect = 1'b0;
      #1;
      checkOutput("alignAddr", romAddr, 64'h100);
      checkOutput("alignPcOut", pcOut, 64'h100);
      checkOutput("alignCe", 64'(romCe), 64'd1);
      applyStimulus();
      checkOutput("alignPcNext", pcOut, 64'h104);

      // Fetch address wraps past the top of the address space.
      applyReset(1'b1, 1);
      #1;
      checkOutput("wrapAddr0", wrapAddr, 64'hFFFF_FFFF_FFFF_FFF8);
      applyStimulus();
      checkOutput("wrapAddr1", wrapAddr, 64'hFFFF_FFFF_FFFF_FFFC);
      checkOutput("wrapCe1", 64'(wrapCe), 64'd1);
      applyStimulus();
      checkOutput("wrapAddr2", wrapAddr, 64'h0);
      applyStimulus();
      checkOutput("wrapAddr3", wrapAddr, 64'h4);
      applyStimulus();
      checkOutput("wrapCeFull", 64'(wrapCe), 64'd0);

      // Spurious response with nothing outstanding sets a sticky error.
      applyReset(1'b0, 1);
      for (int i = 0; i < 8; i++)
         applyStimulus();
      spurPulse = 1'b1;
      applyStimulus();
      checkOutput("spurErrBefore", 64'(err), 64'd0);
      applyStimulus();
      checkOutput("spurErr", 64'(err), 64'd1);
      checkOutput("spurValid", 64'(instValid), 64'd1);
      checkOutput("spurHeadPc", instPc, 64'd0);
      instReady = 1'b1;
      for (int i = 0; i < 4; i++)
         applyStimulus();
      checkOutput("spurDrain", 64'(deliveredCount), 64'd4);
      checkOutput("spurSticky", 64'(err), 64'd1);
      applyReset(1'b1, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
